// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per clock, LSB first,
// with a final borrow flag and a one-cycle done pulse.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;

    // Full-subtractor cell on the current operand LSBs
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_br       <= 1'b0;
            r_cnt      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_res   <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_res_next;
                    // Outputs are published only on the final bit so they never show partial results
                    if (r_cnt == LAST_BIT) begin
                        diff       <= w_res_next;
                        borrow_out <= w_br_next;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases plus a randomized
// back-to-back sweep checked against plain arithmetic.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Present operands with start for exactly one rising edge; returns on the following negedge
    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib);
        @(negedge clk);
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input logic [W-1:0] held, output int busy_n,
                             output bit got, output bit stable);
        busy_n = 0;
        got    = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_n++;
            if (diff !== held) stable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib);
        int          busy_n;
        bit          got;
        bit          stable;
        logic [W-1:0] held;
        logic [W-1:0] exp_d;
        held  = diff;
        exp_d = W'((32'(ia) - 32'(ib)) & 32'hFF);
        start_op(ia, ib);
        wait_done(held, busy_n, got, stable);
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
        check({tag, "_diff_stable_while_busy"}, 32'(stable), 32'd1);
        check({tag, "_diff"}, 32'(diff), 32'(exp_d));
        check({tag, "_borrow"}, 32'(borrow_out), 32'(ia < ib));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    initial begin
        int          busy_n;
        bit          got;
        bit          stable;
        int          n_done;
        int          cyc;
        int          last_done_cyc;
        logic [W-1:0] ea;
        logic [W-1:0] eb;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_borrow", 32'(borrow_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        run_op("op_0a_03", 8'h0A, 8'h03);
        repeat (4) @(negedge clk);
        check("idle_hold_diff", 32'(diff), 32'h07);
        run_op("op_03_0a", 8'h03, 8'h0A);
        run_op("op_00_01", 8'h00, 8'h01);
        run_op("op_ff_ff", 8'hFF, 8'hFF);
        run_op("op_80_7f", 8'h80, 8'h7F);

        // Start pulse during busy must be ignored
        start_op(8'h50, 8'h10);
        @(negedge clk);
        @(negedge clk);
        a = 8'h01; b = 8'h02; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(diff, busy_n, got, stable);
        check("ignore_done_seen", 32'(got), 32'd1);
        check("ignore_diff", 32'(diff), 32'h40);
        check("ignore_borrow", 32'(borrow_out), 32'd0);
        n_done = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("ignore_no_second_op", 32'(n_done), 32'd0);
        check("ignore_diff_hold", 32'(diff), 32'h40);

        // Asynchronous reset in the middle of SHIFT
        start_op(8'h03, 8'h0A);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_diff", 32'(diff), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_borrow", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("midreset_no_activity", 32'(n_done), 32'd0);
        run_op("post_reset_20_01", 8'h20, 8'h01);

        // Start held through reset is accepted on the first edge after release
        @(negedge clk);
        rst_n = 1'b0;
        a = 8'h33; b = 8'h11; start = 1'b1;
        @(negedge clk);
        check("start_in_reset_ignored", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("start_after_release_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(8'h00, busy_n, got, stable);
        check("start_after_release_done", 32'(got), 32'd1);
        check("start_after_release_diff", 32'(diff), 32'h22);
        @(negedge clk);

        // Back-to-back random sweep with start held high
        n_done        = 0;
        cyc           = 0;
        last_done_cyc = -1;
        @(negedge clk);
        a = W'($urandom); b = W'($urandom);
        qa.push_back(a); qb.push_back(b);
        start = 1'b1;
        while (n_done < 1000 && cyc < 10100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                check("sweep_diff", 32'(diff), 32'(W'(ea - eb)));
                check("sweep_borrow", 32'(borrow_out), 32'(ea < eb));
                if (last_done_cyc >= 0)
                    check("sweep_done_spacing", 32'(cyc - last_done_cyc), 32'd10);
                last_done_cyc = cyc;
                n_done++;
                if (n_done < 1000) begin
                    a = W'($urandom); b = W'($urandom);
                    qa.push_back(a); qb.push_back(b);
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("sweep_op_count", 32'(n_done), 32'd1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend, unsigned; captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, unsigned; captured on accepted start.
REQ-007 SHALL have port diff  output  WIDTH  registered result (a - b) mod 2^WIDTH.
REQ-008 SHALL have port borrow_out  output  1  registered final borrow; 1 iff a < b.
REQ-009 SHALL have port busy  output  1  high while in SHIFT state.
REQ-010 SHALL have port done  output  1  single-cycle pulse, result valid.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-012 IDLE: start=1 at a rising edge -> capture a and b into shift registers, clear borrow flop, clear bit counter, go to SHIFT.
REQ-013 IDLE: start=0 -> remain in IDLE; diff and borrow_out hold last values.
REQ-014 SHIFT: each cycle processes one bit LSB-first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-015 SHIFT: operand registers shift right by one; d enters result register at MSB, result shifts right.
REQ-016 SHIFT: after exactly WIDTH bit-cycles (counter reaches WIDTH-1) -> go to DONE; diff and borrow_out update with the final values on that same edge.
REQ-017 DONE: done=1 for exactly one cycle, busy=0; unconditional transition to IDLE next edge.
REQ-018 Latency: start sampled at edge k -> busy high from edge k to edge k+WIDTH; done high for the cycle after edge k+WIDTH; diff valid from edge k+WIDTH.
REQ-019 diff/borrow_out SHALL not change during SHIFT (internal shift register separate from output register) and SHALL hold until the next completed operation.
REQ-020 start asserted in SHIFT or DONE SHALL be ignored; no queuing; a/b changes after capture have no effect.
REQ-021 start held high continuously SHALL start a new operation on the first IDLE edge after DONE (back-to-back period WIDTH+2 cycles).
REQ-022 Bit counter width SHALL be ceil(log2(WIDTH)), no wrap beyond WIDTH-1.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock edge, force state=IDLE, diff=0, borrow_out=0, busy=0, done=0, internal registers and counter=0.
REQ-024 Reset mid-SHIFT SHALL abort the operation; no done pulse after rst_n release; first edge with rst_n=1 behaves as IDLE.
REQ-025 start high while rst_n=0 SHALL be ignored; start still high at first edge after release SHALL be accepted.

Verification (WIDTH=8)
REQ-026 a=0x0A, b=0x03, start 1 cycle -> busy 8 cycles, done pulse 9th cycle, diff=0x07, borrow_out=0.
REQ-027 a=0x03, b=0x0A -> diff=0xF9, borrow_out=1; a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-028 a=0xFF, b=0xFF -> diff=0x00, borrow_out=0; a=0x80, b=0x7F -> diff=0x01, borrow_out=0.
REQ-029 start a=0x50,b=0x10; pulse start with a=0x01,b=0x02 during busy -> single done, diff=0x40, borrow_out=0, no second operation.
REQ-030 start a=0x03,b=0x0A; assert rst_n=0 after 4 SHIFT cycles -> outputs 0 immediately, no done; after release new op a=0x20,b=0x01 -> diff=0x1F.
REQ-031 Random sweep of 1000 operand pairs plus start held high -> each result matches (a-b) mod 256 and a<b, done spacing 10 cycles.
